// File: rtl/fetch_stage.sv
// Fetch front end: PC register, combinational imem address, small in-order queue to decode.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

    logic [31:0]   pc;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          deq;
    logic          full;
    logic          fetch_en;
    logic [31:0]   target;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];
    assign deq       = out_valid && out_ready;
    assign full      = (count == FULL_CNT);
    assign fetch_en  = !redirect_valid && !misalign_err && (!full || deq);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky until an aligned redirect or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_err <= 1'b0;
        else if (redirect_valid)
            misalign_err <= |redirect_pc[1:0];
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch_en) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fetch_en, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (fetch_en && !rst) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, backpressure, redirects, wrap, misalign, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err)
    );

    // Word k of memory lives at byte address 4k.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] p);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, p);
        chk({tag, "_instr"}, out_instr, word(p));
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        rst = 1'b0;

        // Stream with out_ready high
        for (int k = 0; k < 4; k++) begin
            step();
            chk_head("stream", 32'(4 * k));
        end
        chk("stream_addr", imem_addr, 32'h10);

        // Backpressure from a fresh reset
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_head("bp_hold", 32'h0);
        end
        chk("bp_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_head("bp_drain", 32'(4 * k));
        end

        // Queue now holds 0x10, 0x14
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        chk("redir_flush", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h200);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        chk_head("redir_a", 32'h200);
        step();
        chk_head("redir_b", 32'h204);

        // Redirect while the head is being taken
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        chk_head("rdeq_head", 32'h204);
        step();
        chk("rdeq_flush", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_head("rdeq_a", 32'h400);
        step();
        chk_head("rdeq_b", 32'h404);

        // Wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        chk("wrap_flush", 32'(out_valid), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_head("wrap_a", 32'hFFFF_FFF8);
        step();
        chk_head("wrap_b", 32'hFFFF_FFFC);
        step();
        chk_head("wrap_c", 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        chk("mis_flush", 32'(out_valid), 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mis_err", 32'(misalign_err), 32'd1);
            chk("mis_blocked", 32'(out_valid), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        chk("mis_clear", 32'(misalign_err), 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_head("mis_resume", 32'h300);
`else
        step();
        chk_head("mis_ignored", 32'h100);
        chk("mis_err_tied", 32'(misalign_err), 32'd0);
        step();
        chk_head("mis_next", 32'h104);
`endif

        // Fill the queue then assert reset between edges
        out_ready = 1'b0;
        repeat (3) step();
        chk("ar_full", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        step();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
